xreg_wb_arbiter: RTL and testbench



---
 rtl/xreg_pkg.sv | 46 ++++
 rtl/xreg_wb_arbiter_if.sv | 57 +++++
 rtl/xreg_scoreboard.sv | 80 ++++++++
 rtl/xreg_wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_xreg_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xreg_pkg.sv
// Shared definitions for the integer register file write-back path:
// address geometry, requester indices, the output-stage record and a
// one-hot decode helper used by the busy scoreboard.
package xreg_pkg;

    localparam int XREG_ADDR_W = 5;
    localparam int NUM_XREGS   = 32;
    // Width of the data field carried through the output stage; the
    // arbiter's XLEN parameter is expected to match it.
    localparam int XREG_XLEN   = 32;

    // Requester indices used by the arbiter's winner select.
    localparam logic REQ_EXE = 1'b0;
    localparam logic REQ_LL  = 1'b1;

    // One registered write heading for the register file port.
    typedef struct packed {
        logic                   valid;
        logic [XREG_ADDR_W-1:0] addr;
        logic [XREG_XLEN-1:0]   data;
        logic                   fromLL;
    } wb_stage_t;

    localparam wb_stage_t WB_STAGE_IDLE = '{
        valid:  1'b0,
        addr:   5'd0,
        data:   32'd0,
        fromLL: 1'b0
    };

    // Decode a register address into a one-hot mask, all-zero when disabled.
    function automatic logic [NUM_XREGS-1:0] xreg_onehot(
        input logic [XREG_ADDR_W-1:0] addr,
        input logic                   en
    );
        logic [NUM_XREGS-1:0] vec;
        vec = {NUM_XREGS{1'b0}};
        if (en) begin
            vec[addr] = 1'b1;
        end else begin
            vec = {NUM_XREGS{1'b0}};
        end
        return vec;
    endfunction

endpackage

// File: rtl/xreg_wb_arbiter_if.sv
// Bundle of the write-back arbiter's request, reservation, hazard-query and
// register-file write-port signals. The slave side is the arbiter; the
// master side is everything around it (execute, long-latency unit, issue
// logic and the register file).
interface xreg_wb_arbiter_if #(
    parameter int XLEN = 32
);

    logic                               reqValid0;
    logic [xreg_pkg::XREG_ADDR_W-1:0]   reqAddr0;
    logic [XLEN-1:0]                    reqData0;
    logic                               reqReady0;

    logic                               reqValid1;
    logic [xreg_pkg::XREG_ADDR_W-1:0]   reqAddr1;
    logic [XLEN-1:0]                    reqData1;
    logic                               reqReady1;

    logic                               rsvValid;
    logic [xreg_pkg::XREG_ADDR_W-1:0]   rsvAddr;
    logic                               rsvReady;

    logic [xreg_pkg::XREG_ADDR_W-1:0]   qAddr1;
    logic [xreg_pkg::XREG_ADDR_W-1:0]   qAddr2;
    logic                               qBusy1;
    logic                               qBusy2;

    logic                               writeEnable;
    logic [xreg_pkg::XREG_ADDR_W-1:0]   writeAddr;
    logic [XLEN-1:0]                    writeData;
    logic [xreg_pkg::NUM_XREGS-1:0]     busyMask;

    modport master (
        output reqValid0, reqAddr0, reqData0,
        input  reqReady0,
        output reqValid1, reqAddr1, reqData1,
        input  reqReady1,
        output rsvValid, rsvAddr,
        input  rsvReady,
        output qAddr1, qAddr2,
        input  qBusy1, qBusy2,
        input  writeEnable, writeAddr, writeData, busyMask
    );

    modport slave (
        input  reqValid0, reqAddr0, reqData0,
        output reqReady0,
        input  reqValid1, reqAddr1, reqData1,
        output reqReady1,
        input  rsvValid, rsvAddr,
        output rsvReady,
        input  qAddr1, qAddr2,
        output qBusy1, qBusy2,
        output writeEnable, writeAddr, writeData, busyMask
    );

endinterface

// File: rtl/xreg_scoreboard.sv
// Busy scoreboard for long-latency destinations. A bit is set when a
// reservation is accepted and cleared when the long-latency result leaves
// the output stage. A reservation landing on the address being cleared in
// the same cycle is accepted, and the new reservation wins.
module xreg_scoreboard
    import xreg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_en,
    input  logic [XREG_ADDR_W-1:0] clr_addr,
    input  logic                   rsv_valid,
    input  logic [XREG_ADDR_W-1:0] rsv_addr,
    output logic                   rsv_ready,
    input  logic [XREG_ADDR_W-1:0] q_addr1,
    input  logic [XREG_ADDR_W-1:0] q_addr2,
    output logic                   q_busy1,
    output logic                   q_busy2,
    output logic [NUM_XREGS-1:0]   busy_mask
);

    logic [NUM_XREGS-1:0] busy_r;
    logic [NUM_XREGS-1:0] busy_nxt_s;
    logic [NUM_XREGS-1:0] set_mask_s;
    logic [NUM_XREGS-1:0] clr_mask_s;
    logic                 rsv_ready_s;
    logic                 q_busy1_s;
    logic                 q_busy2_s;

    // Reservation acceptance, set/clear masks and next busy vector.
    always_comb begin
        rsv_ready_s = 1'b0;
        if (rst) begin
            rsv_ready_s = 1'b0;
        end else if (rsv_addr == 5'd0) begin
            rsv_ready_s = 1'b1;
        end else if (!busy_r[rsv_addr]) begin
            rsv_ready_s = 1'b1;
        end else begin
            // Busy, but its result retires this cycle: slot frees in time.
            rsv_ready_s = clr_en && (clr_addr == rsv_addr);
        end
        set_mask_s = xreg_onehot(rsv_addr,
                                 rsv_valid && rsv_ready_s && (rsv_addr != 5'd0));
        clr_mask_s = xreg_onehot(clr_addr, clr_en);
        // Set applied after clear so a same-address reservation survives.
        busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // Hazard queries; x0 is never busy.
    always_comb begin
        q_busy1_s = 1'b0;
        q_busy2_s = 1'b0;
        if (q_addr1 != 5'd0) begin
            q_busy1_s = busy_r[q_addr1];
        end else begin
            q_busy1_s = 1'b0;
        end
        if (q_addr2 != 5'd0) begin
            q_busy2_s = busy_r[q_addr2];
        end else begin
            q_busy2_s = 1'b0;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {NUM_XREGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign rsv_ready = rsv_ready_s;
    assign q_busy1   = q_busy1_s;
    assign q_busy2   = q_busy2_s;
    assign busy_mask = busy_r;

endmodule

// File: rtl/xreg_wb_arbiter.sv
// Write-back arbiter for the integer register file's single write port.
// Requester 0 (execute) wins conflicts by default; requester 1 (long-latency
// unit) also tracks its destinations in a busy scoreboard. Writes to x0 are
// always accepted and discarded without using the port.
// Optional feature macro: XREG_WB_ANTISTARVE_EN -- when defined, a starve
// counter forces a grant to requester 1 after STARVE_LIMIT denied cycles;
// when undefined, requester 0 has strict priority.
module xreg_wb_arbiter
    import xreg_pkg::*;
#(
    parameter int XLEN         = XREG_XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    xreg_wb_arbiter_if.slave bus
);

    logic            null0_s;
    logic            null1_s;
    logic            live0_s;
    logic            live1_s;
    logic            force1_s;
    logic            ready0_s;
    logic            ready1_s;
    logic            take0_s;
    logic            take1_s;
    logic            winner_s;
    logic [XLEN-1:0] data0_s;
    logic [XLEN-1:0] data1_s;
    wb_stage_t       out_nxt_s;
    wb_stage_t       out_r;
    logic            clr_en_s;

    assign data0_s = bus.reqData0;
    assign data1_s = bus.reqData1;

    // Classify each request as null (x0) or live (valid, needs the port).
    always_comb begin
        null0_s = (bus.reqAddr0 == 5'd0);
        null1_s = (bus.reqAddr1 == 5'd0);
        live0_s = bus.reqValid0 && !null0_s;
        live1_s = bus.reqValid1 && !null1_s;
    end

`ifdef XREG_WB_ANTISTARVE_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] starve_r;
    logic [3:0] starve_nxt_s;

    assign force1_s = (starve_r == LIMIT_C);

    // Count consecutive denied cycles of a live requester 1, saturating.
    always_comb begin
        starve_nxt_s = 4'd0;
        if (live1_s && !ready1_s) begin
            if (starve_r == LIMIT_C) begin
                starve_nxt_s = starve_r;
            end else begin
                starve_nxt_s = starve_r + 4'd1;
            end
        end else begin
            starve_nxt_s = 4'd0;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_r <= 4'd0;
        end else begin
            starve_r <= starve_nxt_s;
        end
    end
`else
    assign force1_s = 1'b0;
`endif

    // Ready generation: only two live requests conflict for the port.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (rst) begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end else begin
            ready0_s = null0_s || !(live1_s && force1_s);
            ready1_s = null1_s || !live0_s || force1_s;
        end
    end

    // Pick the single accepted live write and build the next output stage.
    always_comb begin
        take0_s   = live0_s && ready0_s;
        take1_s   = live1_s && ready1_s;
        winner_s  = REQ_EXE;
        out_nxt_s = WB_STAGE_IDLE;
        if (take0_s) begin
            winner_s = REQ_EXE;
        end else begin
            winner_s = REQ_LL;
        end
        if (take0_s || take1_s) begin
            case (winner_s)
                REQ_EXE: out_nxt_s = '{valid: 1'b1, addr: bus.reqAddr0,
                                       data: data0_s, fromLL: 1'b0};
                REQ_LL:  out_nxt_s = '{valid: 1'b1, addr: bus.reqAddr1,
                                       data: data1_s, fromLL: 1'b1};
                default: out_nxt_s = WB_STAGE_IDLE;
            endcase
        end else begin
            out_nxt_s = WB_STAGE_IDLE;
        end
    end

    // Output stage: holds each accepted write for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= WB_STAGE_IDLE;
        end else begin
            out_r <= out_nxt_s;
        end
    end

    // Only long-latency results retire a scoreboard entry.
    assign clr_en_s = out_r.valid && out_r.fromLL;

    xreg_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .clr_en    (clr_en_s),
        .clr_addr  (out_r.addr),
        .rsv_valid (bus.rsvValid),
        .rsv_addr  (bus.rsvAddr),
        .rsv_ready (bus.rsvReady),
        .q_addr1   (bus.qAddr1),
        .q_addr2   (bus.qAddr2),
        .q_busy1   (bus.qBusy1),
        .q_busy2   (bus.qBusy2),
        .busy_mask (bus.busyMask)
    );

    assign bus.reqReady0   = ready0_s;
    assign bus.reqReady1   = ready1_s;
    assign bus.writeEnable = out_r.valid;
    assign bus.writeAddr   = out_r.addr;
    assign bus.writeData   = out_r.data;

endmodule

// File: tb/tb_xreg_wb_arbiter.sv
// Bench for xreg_wb_arbiter: directed scenarios with hand-computed results,
// then randomized traffic, all shadowed every cycle by a behavioural model.
module tb_xreg_wb_arbiter;
    import xreg_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    initial forever #5 clk = ~clk;

    xreg_wb_arbiter_if #(.XLEN(32)) bus ();

    xreg_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit model_ok = 1'b0;
    bit done = 1'b0;

    // Model state: what the spec says the registered outputs hold.
    logic [31:0] m_busy = 32'd0;
    bit          m_we = 1'b0;
    bit          m_ll = 1'b0;
    logic [4:0]  m_wa = 5'd0;
    logic [31:0] m_wd = 32'd0;
    int          m_starve = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.reqValid0 = 1'b0; bus.reqAddr0 = 5'd0; bus.reqData0 = 32'd0;
        bus.reqValid1 = 1'b0; bus.reqAddr1 = 5'd0; bus.reqData1 = 32'd0;
        bus.rsvValid  = 1'b0; bus.rsvAddr  = 5'd0;
        bus.qAddr1    = 5'd0; bus.qAddr2   = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle model compare and model advance, at the falling edge.
    initial begin
        bit          live0, live1, forced, clearing;
        bit          e_r0, e_r1, e_rsv, e_q1, e_q2;
        logic [31:0] nb;
        forever begin
            @(negedge clk);
            live0 = bus.reqValid0 && (bus.reqAddr0 != 5'd0);
            live1 = bus.reqValid1 && (bus.reqAddr1 != 5'd0);
`ifdef XREG_WB_ANTISTARVE_EN
            forced = (m_starve == LIMIT);
`else
            forced = 1'b0;
`endif
            clearing = m_we && m_ll;
            if (rst) begin
                e_r0 = 1'b0; e_r1 = 1'b0; e_rsv = 1'b0;
            end else begin
                // Requester 0 loses only a live-vs-live fight when forced.
                e_r0 = (bus.reqAddr0 == 5'd0) || !(live1 && forced);
                e_r1 = (bus.reqAddr1 == 5'd0) || !live0 || forced;
                e_rsv = (bus.rsvAddr == 5'd0) || !m_busy[bus.rsvAddr]
                        || (clearing && m_wa == bus.rsvAddr);
            end
            e_q1 = (bus.qAddr1 != 5'd0) && m_busy[bus.qAddr1];
            e_q2 = (bus.qAddr2 != 5'd0) && m_busy[bus.qAddr2];
            if (model_ok && !done) begin
                check("m.reqReady0", 64'(bus.reqReady0), 64'(e_r0));
                check("m.reqReady1", 64'(bus.reqReady1), 64'(e_r1));
                check("m.rsvReady", 64'(bus.rsvReady), 64'(e_rsv));
                check("m.qBusy1", 64'(bus.qBusy1), 64'(e_q1));
                check("m.qBusy2", 64'(bus.qBusy2), 64'(e_q2));
                check("m.writeEnable", 64'(bus.writeEnable), 64'(m_we));
                check("m.writeAddr", 64'(bus.writeAddr), 64'(m_wa));
                check("m.writeData", 64'(bus.writeData), 64'(m_wd));
                check("m.busyMask", 64'(bus.busyMask), 64'(m_busy));
            end
            if (rst) begin
                m_busy = 32'd0; m_we = 1'b0; m_ll = 1'b0;
                m_wa = 5'd0; m_wd = 32'd0; m_starve = 0;
                model_ok = 1'b1;
            end else begin
                nb = m_busy;
                if (clearing) nb[m_wa] = 1'b0;
                if (bus.rsvValid && e_rsv && bus.rsvAddr != 5'd0) nb[bus.rsvAddr] = 1'b1;
                m_busy = nb;
                if (live0 && e_r0) begin
                    m_we = 1'b1; m_ll = 1'b0; m_wa = bus.reqAddr0; m_wd = bus.reqData0;
                end else if (live1 && e_r1) begin
                    m_we = 1'b1; m_ll = 1'b1; m_wa = bus.reqAddr1; m_wd = bus.reqData1;
                end else begin
                    m_we = 1'b0; m_ll = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
                end
                if (live1 && !e_r1) m_starve = (m_starve >= LIMIT) ? LIMIT : m_starve + 1;
                else m_starve = 0;
            end
        end
    end

    // Directed scenarios followed by random traffic.
    initial begin
        int grants;
        int first_grant;
        int exp_grants;
        int exp_first;
`ifdef XREG_WB_ANTISTARVE_EN
        exp_grants = 2; exp_first = 5;
`else
        exp_grants = 0; exp_first = 0;
`endif
        idle();
        rst = 1'b1;

        // Readies held low while reset is asserted.
        step();
        rst = 1'b1;
        bus.reqValid0 = 1'b1; bus.reqAddr0 = 5'd5;
        bus.reqValid1 = 1'b1; bus.reqAddr1 = 5'd6;
        bus.rsvValid = 1'b1; bus.rsvAddr = 5'd3;
        #2;
        check("rst.reqReady0", 64'(bus.reqReady0), 64'd0);
        check("rst.reqReady1", 64'(bus.reqReady1), 64'd0);
        check("rst.rsvReady", 64'(bus.rsvReady), 64'd0);

        step();
        rst = 1'b0; idle();
        #2;
        check("rst.writeEnable", 64'(bus.writeEnable), 64'd0);
        check("rst.writeAddr", 64'(bus.writeAddr), 64'd0);
        check("rst.busyMask", 64'(bus.busyMask), 64'd0);

        // Single requester-0 write: one cycle of writeEnable.
        bus.reqValid0 = 1'b1; bus.reqAddr0 = 5'd5; bus.reqData0 = 32'hDEADBEEF;
        #1;
        check("w0.reqReady0", 64'(bus.reqReady0), 64'd1);
        step(); idle(); #2;
        check("w0.writeEnable", 64'(bus.writeEnable), 64'd1);
        check("w0.writeAddr", 64'(bus.writeAddr), 64'd5);
        check("w0.writeData", 64'(bus.writeData), 64'hDEADBEEF);
        step(); #2;
        check("w0.writeEnable_off", 64'(bus.writeEnable), 64'd0);

        // Continuous conflict: requester 1 grant pattern.
        grants = 0; first_grant = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            bus.reqValid0 = 1'b1; bus.reqAddr0 = 5'd1; bus.reqData0 = 32'(c);
            bus.reqValid1 = 1'b1; bus.reqAddr1 = 5'd2; bus.reqData1 = 32'(c + 100);
            #2;
            if (bus.reqReady1) begin
                grants++;
                if (first_grant == 0) first_grant = c;
            end
        end
        step(); idle();
        check("starve.grants", 64'(grants), 64'(exp_grants));
        check("starve.first_grant", 64'(first_grant), 64'(exp_first));
        step();

        // Reserve x7, query it, retire it through requester 1.
        step(); idle(); bus.rsvValid = 1'b1; bus.rsvAddr = 5'd7; #2;
        check("sb.rsvReady", 64'(bus.rsvReady), 64'd1);
        step(); idle(); bus.qAddr1 = 5'd7; #2;
        check("sb.qBusy1", 64'(bus.qBusy1), 64'd1);
        check("sb.busy7_set", 64'(bus.busyMask[7]), 64'd1);
        bus.reqValid1 = 1'b1; bus.reqAddr1 = 5'd7; bus.reqData1 = 32'h77; #1;
        check("sb.reqReady1", 64'(bus.reqReady1), 64'd1);
        step(); idle(); #2;
        check("sb.writeEnable", 64'(bus.writeEnable), 64'd1);
        check("sb.busy7_before_clear", 64'(bus.busyMask[7]), 64'd1);
        step(); #2;
        check("sb.busy7_cleared", 64'(bus.busyMask[7]), 64'd0);

        // Reservation of x7 on the edge its previous result retires.
        step(); idle(); bus.rsvValid = 1'b1; bus.rsvAddr = 5'd7;
        step(); idle(); bus.reqValid1 = 1'b1; bus.reqAddr1 = 5'd7; bus.reqData1 = 32'h78;
        step(); idle(); bus.rsvValid = 1'b1; bus.rsvAddr = 5'd7; #2;
        check("setwins.writeAddr", 64'(bus.writeAddr), 64'd7);
        check("setwins.rsvReady", 64'(bus.rsvReady), 64'd1);
        step(); idle(); #2;
        check("setwins.busyMask", 64'(bus.busyMask), 64'h80);

        // Live x3 from requester 0 alongside a null write from requester 1.
        bus.reqValid0 = 1'b1; bus.reqAddr0 = 5'd3; bus.reqData0 = 32'h33;
        bus.reqValid1 = 1'b1; bus.reqAddr1 = 5'd0; bus.reqData1 = 32'h44;
        #2;
        check("null.reqReady0", 64'(bus.reqReady0), 64'd1);
        check("null.reqReady1", 64'(bus.reqReady1), 64'd1);
        step(); idle(); #2;
        check("null.writeAddr", 64'(bus.writeAddr), 64'd3);
        check("null.writeData", 64'(bus.writeData), 64'h33);
        step(); #2;
        check("null.writeEnable_off", 64'(bus.writeEnable), 64'd0);
        check("null.busyMask", 64'(bus.busyMask), 64'h80);

        // Reset with x9 reserved and a write sitting in the output stage.
        step(); idle(); bus.rsvValid = 1'b1; bus.rsvAddr = 5'd9;
        step(); idle(); bus.reqValid0 = 1'b1; bus.reqAddr0 = 5'd4; bus.reqData0 = 32'h44;
        step(); idle(); rst = 1'b1;
        bus.reqValid0 = 1'b1; bus.reqAddr0 = 5'd4;
        bus.reqValid1 = 1'b1; bus.reqAddr1 = 5'd5;
        bus.rsvValid = 1'b1; bus.rsvAddr = 5'd10;
        #2;
        check("mid.pending_we", 64'(bus.writeEnable), 64'd1);
        check("mid.busy_before", 64'(bus.busyMask), 64'h280);
        check("mid.reqReady0", 64'(bus.reqReady0), 64'd0);
        step(); #2;
        check("mid.writeEnable", 64'(bus.writeEnable), 64'd0);
        check("mid.busyMask", 64'(bus.busyMask), 64'd0);
        check("mid.reqReady1", 64'(bus.reqReady1), 64'd0);
        check("mid.rsvReady", 64'(bus.rsvReady), 64'd0);
        step(); rst = 1'b0; idle();

        // Random traffic over a small address range to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            bus.reqValid0 = ($urandom_range(0, 3) != 0);
            bus.reqAddr0 = 5'($urandom_range(0, 7));
            bus.reqData0 = $urandom;
            bus.reqValid1 = ($urandom_range(0, 4) != 0);
            bus.reqAddr1 = 5'($urandom_range(0, 7));
            bus.reqData1 = $urandom;
            bus.rsvValid = ($urandom_range(0, 2) == 0);
            bus.rsvAddr = 5'($urandom_range(0, 7));
            bus.qAddr1 = 5'($urandom_range(0, 7));
            bus.qAddr2 = 5'($urandom_range(0, 31));
        end
        step(); idle(); rst = 1'b0;
        step();
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
